// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, issues word requests under a credit limit, pairs in-order
// responses with their fetch addresses and buffers them for the instruction FIFO.
module fetch_unit #(
  parameter int               XLEN            = 32,
  parameter logic [XLEN-1:0]  RESET_PC        = 32'h1000_0000,
  parameter int               MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            fetch_ready_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_addr_o,
  output logic [XLEN-1:0] out_instr_o,
  output logic            clear_o
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  state_t          state, state_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] aq [MAX_OUTSTANDING];
  logic [XLEN-1:0] rb_addr [MAX_OUTSTANDING];
  logic [XLEN-1:0] rb_data [MAX_OUTSTANDING];
  logic [PW-1:0]   aq_wr, aq_rd, rb_wr, rb_rd;
  logic [CW-1:0]   rb_cnt, inflight, discard_cnt, discard_d;
  logic            grant, live, drop, pop;
  logic            unused_pc_bit0;
  assign unused_pc_bit0 = redirect_pc_i[0];
  assign imem_req_o  = (state != BOOT) && (inflight + rb_cnt < CW'(MAX_OUTSTANDING)) && !redirect_i;
  assign imem_addr_o = (state == BOOT) ? '0 : {pc[XLEN-1:2], 2'b00};
  assign grant       = imem_req_o & imem_gnt_i;
  // stale responses are consumed first; an rvalid with nothing outstanding is ignored
  assign drop        = imem_rvalid_i && (discard_cnt != '0);
  assign live        = imem_rvalid_i && (discard_cnt == '0) && (inflight != '0);
  assign out_valid_o = rb_cnt != '0;
  assign pop         = out_valid_o & fetch_ready_i;
  assign out_addr_o  = out_valid_o ? rb_addr[rb_rd] : '0;
  assign out_instr_o = out_valid_o ? rb_data[rb_rd] : '0;
  assign clear_o     = redirect_i;
  always_comb begin
    discard_d = redirect_i ? discard_cnt + inflight - CW'(drop | live) : discard_cnt - CW'(drop);
    state_d   = (discard_d != '0) ? DRAIN : RUN;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      aq_wr       <= '0;
      aq_rd       <= '0;
      rb_wr       <= '0;
      rb_rd       <= '0;
      rb_cnt      <= '0;
      inflight    <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_d;
      discard_cnt <= discard_d;
      if (redirect_i) begin
        pc       <= {redirect_pc_i[XLEN-1:1], 1'b0};
        aq_wr    <= '0;
        aq_rd    <= '0;
        rb_wr    <= '0;
        rb_rd    <= '0;
        rb_cnt   <= '0;
        inflight <= '0;
      end else begin
        if (grant) begin
          pc    <= {pc[XLEN-1:2], 2'b00} + XLEN'(4);
          aq_wr <= aq_wr + 1'b1;
        end
        if (live) begin
          aq_rd <= aq_rd + 1'b1;
          rb_wr <= rb_wr + 1'b1;
        end
        if (pop) rb_rd <= rb_rd + 1'b1;
        inflight <= inflight + CW'(grant) - CW'(live);
        rb_cnt   <= rb_cnt + CW'(live) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (grant) aq[aq_wr] <= pc;
    if (live) begin
      rb_addr[rb_wr] <= aq[aq_rd];
      rb_data[rb_wr] <= imem_rdata_i;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against an in-order
// memory model and a scoreboard of expected {pc, word} deliveries.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h1000_0000;
  localparam int MAXO = 2;
  logic clk = 0, rst_n = 0, redirect = 0, fetch_ready = 0, gnt = 0, rvalid = 0;
  logic [31:0] redirect_pc = '0, rdata = '0;
  logic req, ovalid, clear;
  logic [31:0] addr, oaddr, oinstr;
  typedef struct {logic [31:0] a; logic [31:0] d;} exp_t;
  typedef struct {int t; logic [31:0] a;} pend_t;
  exp_t exp_q[$];
  pend_t pend_q[$];
  logic [31:0] model_pc = RESET_PC;
  int cyc = 0, last_t = 0, lat_lo = 0, lat_hi = 0, n_cmp = 0, n_bad = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .fetch_ready_i(fetch_ready), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .out_valid_o(ovalid),
    .out_addr_o(oaddr), .out_instr_o(oinstr), .clear_o(clear));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // in-order memory: each granted word returns 1+lat cycles later, one per cycle
  task automatic memory();
    forever begin
      @(posedge clk); cyc++; #1;
      if (!rst_n) begin
        pend_q.delete(); rvalid = 0;
      end else if (pend_q.size() != 0 && pend_q[0].t <= cyc) begin
        rvalid = 1; rdata = mem_word(pend_q[0].a); void'(pend_q.pop_front());
      end else begin
        rvalid = 0; rdata = $urandom;
      end
    end
  endtask

  task automatic monitor();
    exp_t e; pend_t p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); pend_q.delete(); last_t = 0; model_pc = RESET_PC;
      end else begin
        n_cmp++;
        if (clear !== redirect) begin n_bad++; $display("FAIL clear_o: got %b want %b", clear, redirect); end
        if (redirect) begin
          n_cmp++;
          if (req !== 1'b0) begin n_bad++; $display("FAIL req_on_redirect: got %b want 0", req); end
          exp_q.delete();
          model_pc = redirect_pc & ~32'h1;
        end else begin
          if (ovalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++; $display("FAIL spurious_out: got addr %h with nothing expected", oaddr);
            end else if (fetch_ready) begin
              if (oaddr !== exp_q[0].a || oinstr !== exp_q[0].d) begin
                n_bad++; $display("FAIL out_word: got %h/%h want %h/%h", oaddr, oinstr, exp_q[0].a, exp_q[0].d);
              end
              void'(exp_q.pop_front());
            end
          end
          if (req && gnt) begin
            n_cmp++;
            if (addr !== {model_pc[31:2], 2'b00}) begin
              n_bad++; $display("FAIL req_addr: got %h want %h", addr, {model_pc[31:2], 2'b00});
            end
            e.a = model_pc; e.d = mem_word({model_pc[31:2], 2'b00});
            exp_q.push_back(e);
            model_pc = {model_pc[31:2], 2'b00} + 32'd4;
          end
          n_cmp++;
          if (exp_q.size() > MAXO) begin n_bad++; $display("FAIL credits: got %0d outstanding want <= %0d", exp_q.size(), MAXO); end
        end
        if (req && gnt) begin
          p.a = addr; p.t = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
          if (p.t <= last_t) p.t = last_t + 1;
          last_t = p.t;
          pend_q.push_back(p);
        end
      end
    end
  endtask

  task automatic drain();
    bit done = 0;
    tick(); gnt = 0; fetch_ready = 1; redirect = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (pend_q.size() == 0 && !rvalid && !ovalid) done = 1;
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL drain_timeout: got busy want idle"); end
    else if (exp_q.size() != 0) begin n_bad++; $display("FAIL lost_words: got %0d undelivered want 0", exp_q.size()); end
  endtask

  task automatic wait_grants(input int n);
    int g = 0;
    for (int k = 0; k < 12 && g < n; k++) begin
      @(negedge clk);
      if (req && gnt) g++;
    end
    n_cmp++;
    if (g != n) begin n_bad++; $display("FAIL grant_setup: got %0d want %0d", g, n); end
  endtask

  task automatic wait_out(input string name, input logic [31:0] wa);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (ovalid) seen = 1;
    end
    n_cmp++;
    if (!seen || oaddr !== wa || oinstr !== mem_word({wa[31:2], 2'b00})) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h want 1/%h/%h", name, seen, oaddr, oinstr, wa, mem_word({wa[31:2], 2'b00}));
    end
  endtask

  task automatic test_reset();
    rst_n = 0; lat_lo = 0; lat_hi = 0;
    repeat (2) tick();
    n_cmp++;
    if ({req, addr, ovalid, oaddr, oinstr, clear} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %b/%h/%b/%h/%h/%b want all 0", req, addr, ovalid, oaddr, oinstr, clear);
    end
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b0) begin n_bad++; $display("FAIL boot_req: got %b want 0", req); end
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || addr !== RESET_PC) begin n_bad++; $display("FAIL first_req: got %b/%h want 1/%h", req, addr, RESET_PC); end
  endtask

  task automatic test_basic();
    logic [31:0] ga[$], oa[$];
    logic [31:0] want = '0;
    bit chk = 0;
    int nr = 0;
    tick(); gnt = 1; fetch_ready = 1;
    repeat (16) begin
      @(negedge clk);
      if (chk) begin
        n_cmp++;
        if (ovalid !== 1'b1 || oaddr !== want) begin n_bad++; $display("FAIL out_latency: got %b/%h want 1/%h", ovalid, oaddr, want); end
      end
      chk = rvalid && nr < ga.size();
      if (chk) begin want = ga[nr]; nr++; end
      if (ovalid) oa.push_back(oaddr);
      if (req && gnt) ga.push_back(addr);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ga.size() <= i || ga[i] !== RESET_PC + 32'(4 * i)) begin n_bad++; $display("FAIL basic_req%0d: got %h want %h", i, ga.size() > i ? ga[i] : 32'hx, RESET_PC + 32'(4 * i)); end
      n_cmp++;
      if (oa.size() <= i || oa[i] !== RESET_PC + 32'(4 * i)) begin n_bad++; $display("FAIL basic_out%0d: got %h want %h", i, oa.size() > i ? oa[i] : 32'hx, RESET_PC + 32'(4 * i)); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int g = 0;
    logic [31:0] first = '0;
    tick(); gnt = 1; fetch_ready = 0; lat_lo = 0; lat_hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (req && gnt) begin
        if (g == 0) first = addr;
        g++;
      end
    end
    n_cmp++;
    if (g != MAXO) begin n_bad++; $display("FAIL bp_grants: got %0d want %0d", g, MAXO); end
    n_cmp++;
    if (req !== 1'b0) begin n_bad++; $display("FAIL bp_req_stop: got %b want 0", req); end
    n_cmp++;
    if (ovalid !== 1'b1 || oaddr !== first) begin n_bad++; $display("FAIL bp_hold: got %b/%h want 1/%h", ovalid, oaddr, first); end
    drain();
  endtask

  task automatic test_redirect();
    tick(); gnt = 1; fetch_ready = 1; lat_lo = 2; lat_hi = 2;
    wait_grants(2);
    tick(); redirect = 1; redirect_pc = 32'h2000_0006;
    @(negedge clk);
    n_cmp++;
    if (clear !== 1'b1) begin n_bad++; $display("FAIL redir_clear: got %b want 1", clear); end
    tick(); redirect = 0;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || addr !== 32'h2000_0004) begin n_bad++; $display("FAIL redir_req: got %b/%h want 1/20000004", req, addr); end
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      n_cmp++;
      if (ovalid !== 1'b0) begin n_bad++; $display("FAIL redir_stale%0d: got %b want 0", k, ovalid); end
    end
    wait_out("redir_first", 32'h2000_0006);
    wait_out("redir_second", 32'h2000_0008);
    drain();
  endtask

  task automatic test_redirect_rvalid();
    tick(); gnt = 1; fetch_ready = 1; lat_lo = 2; lat_hi = 2;
    wait_grants(2);
    tick();
    tick(); redirect = 1; redirect_pc = 32'h3000_0010;
    @(negedge clk);
    n_cmp++;
    if (clear !== 1'b1 || rvalid !== 1'b1) begin n_bad++; $display("FAIL rr_setup: got clear %b rvalid %b want 1/1", clear, rvalid); end
    tick(); redirect = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ovalid !== 1'b0) begin n_bad++; $display("FAIL rr_drop%0d: got %b want 0", k, ovalid); end
    end
    wait_out("rr_first", 32'h3000_0010);
    drain();
  endtask

  task automatic test_gnt_delay();
    logic [31:0] a0;
    tick(); gnt = 0; fetch_ready = 1;
    @(negedge clk);
    a0 = addr;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      n_cmp++;
      if (req !== 1'b1 || addr !== a0) begin n_bad++; $display("FAIL gd_hold%0d: got %b/%h want 1/%h", k, req, addr, a0); end
    end
    tick(); gnt = 1;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || addr !== a0) begin n_bad++; $display("FAIL gd_grant: got %b/%h want 1/%h", req, addr, a0); end
    tick(); gnt = 0;
    @(negedge clk);
    n_cmp++;
    if (addr !== a0 + 32'd4) begin n_bad++; $display("FAIL gd_next: got %h want %h", addr, a0 + 32'd4); end
    drain();
  endtask

  task automatic test_reset_drain();
    tick(); gnt = 1; fetch_ready = 1; lat_lo = 3; lat_hi = 3;
    wait_grants(2);
    tick(); redirect = 1; redirect_pc = 32'h4000_0000;
    tick(); redirect = 0;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({req, addr, ovalid, oaddr, oinstr, clear} !== '0) begin
      n_bad++; $display("FAIL rd_outputs: got %b/%h/%b/%h/%h/%b want all 0", req, addr, ovalid, oaddr, oinstr, clear);
    end
    tick(); tick(); rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || addr !== RESET_PC) begin n_bad++; $display("FAIL rd_restart: got %b/%h want 1/%h", req, addr, RESET_PC); end
    wait_out("rd_first", RESET_PC);
    drain();
  endtask

  task automatic test_random();
    lat_lo = 0; lat_hi = 3;
    repeat (500) begin
      tick();
      gnt = $urandom_range(0, 3) != 0;
      fetch_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 24) == 0;
      redirect_pc = $urandom;
    end
    drain();
  endtask

  initial begin
    fork
      memory();
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid();
    test_gnt_delay();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
